// File: rtl/quad_enc_gen.sv
// Quadrature encoder pattern generator: emits a commanded number of A/B
// edges at a fixed period and keeps a signed running position.
module quad_enc_gen #(
    parameter int PERIOD_WIDTH = 16,
    parameter int STEP_WIDTH   = 16,
    parameter int POS_WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_dir,
    input  logic [STEP_WIDTH-1:0]       cmd_steps,
    input  logic [PERIOD_WIDTH-1:0]     cmd_period,
    input  logic                        abort,
    output logic                        enc_a,
    output logic                        enc_b,
    output logic                        busy,
    output logic                        done,
    output logic signed [POS_WIDTH-1:0] position
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                  state_q, state_d;
    logic                    dir_q, dir_d;
    logic [STEP_WIDTH-1:0]   steps_q, steps_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]              ab_q, ab_d;
    logic [POS_WIDTH-1:0]    pos_q, pos_d;
    logic                    done_q, done_d;
    logic [PERIOD_WIDTH-1:0] period_eff;

    // A zero period would never fire; run it as one cycle per edge.
    assign period_eff = (cmd_period == '0) ? PERIOD_WIDTH'(1) : cmd_period;

    function automatic logic [1:0] next_phase(input logic [1:0] ab,
                                              input logic       rev);
        logic [1:0] nx;
        nx = 2'b00;
        unique case (ab)
            2'b00: nx = rev ? 2'b01 : 2'b10;
            2'b10: nx = rev ? 2'b00 : 2'b11;
            2'b11: nx = rev ? 2'b10 : 2'b01;
            2'b01: nx = rev ? 2'b11 : 2'b00;
        endcase
        return nx;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            dir_q    <= 1'b0;
            steps_q  <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            ab_q     <= 2'b00;
            pos_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            steps_q  <= steps_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            ab_q     <= ab_d;
            pos_q    <= pos_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        steps_d  = steps_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        ab_d     = ab_q;
        pos_d    = pos_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    dir_d    = cmd_dir;
                    steps_d  = cmd_steps;
                    period_d = period_eff;
                    cnt_d    = period_eff - PERIOD_WIDTH'(1);
                    if (cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Abort wins over a coincident step edge.
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    ab_d    = next_phase(ab_q, dir_q);
                    pos_d   = dir_q ? pos_q - POS_WIDTH'(1)
                                    : pos_q + POS_WIDTH'(1);
                    cnt_d   = period_q - PERIOD_WIDTH'(1);
                    steps_d = steps_q - STEP_WIDTH'(1);
                    if (steps_q == STEP_WIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - PERIOD_WIDTH'(1);
                end
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign enc_a     = ab_q[1];
    assign enc_b     = ab_q[0];
    assign position  = pos_q;

endmodule

// File: tb/tb_quad_enc_gen.sv
// Bench for quad_enc_gen: command table plus hand-written abort, wrap,
// busy-ignore and async-reset sequences, checked via an edge scoreboard.
module tb_quad_enc_gen;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [15:0] cmd_steps;
    logic [15:0] cmd_period;
    logic        abort;
    logic        enc_a;
    logic        enc_b;
    logic        busy;
    logic        done;
    logic [15:0] position;

    quad_enc_gen #(
        .PERIOD_WIDTH(16),
        .STEP_WIDTH  (16),
        .POS_WIDTH   (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .cmd_period(cmd_period),
        .abort     (abort),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .busy      (busy),
        .done      (done),
        .position  (position)
    );

    typedef struct {
        int         t;
        logic [1:0] ab;
        logic [15:0] pos;
        logic       dn;
    } ev_t;

    typedef struct {
        bit          rst;
        bit          dir;
        int          steps;
        int          per;
        logic [1:0]  fab;
        logic [15:0] fpos;
    } vec_t;

    ev_t         sb[$];
    vec_t        vec[6];
    int          cyc;
    int          n_chk;
    int          n_fail;
    bit          mon_en;
    logic [1:0]  prev_ab;
    int          exp_idx;
    logic [15:0] exp_pos;
    logic [1:0]  seq[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    // Each visible phase change or done pulse must match the queue head.
    always @(negedge clk) begin
        ev_t ev;
        if (mon_en) begin
            if ({enc_a, enc_b} != prev_ab || done) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_event: got ab=%b done=%b expected none (cycle %0d)",
                             {enc_a, enc_b}, done, cyc);
                end else begin
                    ev = sb.pop_front();
                    chk("ev_cycle", 32'(cyc), 32'(ev.t));
                    chk("ev_ab", 32'({enc_a, enc_b}), 32'(ev.ab));
                    chk("ev_pos", 32'(position), 32'(ev.pos));
                    chk("ev_done", 32'(done), 32'(ev.dn));
                end
            end
            prev_ab = {enc_a, enc_b};
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_ab", 32'({enc_a, enc_b}), 32'(2'b00));
        chk("rst_pos", 32'(position), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        exp_idx = 0;
        exp_pos = 16'h0;
        prev_ab = 2'b00;
        mon_en  = 1'b1;
        @(negedge clk);
    endtask

    // Called just after a negedge; returns at the negedge after the accept edge.
    task automatic send(bit d, int steps, int per, int lim, output int a);
        ev_t ev;
        int  eff;
        eff = (per == 0) ? 1 : per;
        a = cyc + 1;
        cmd_dir    = d;
        cmd_steps  = 16'(steps);
        cmd_period = 16'(per);
        cmd_valid  = 1'b1;
        if (steps == 0) begin
            ev.t = a; ev.ab = seq[exp_idx]; ev.pos = exp_pos; ev.dn = 1'b1;
            sb.push_back(ev);
        end else begin
            for (int k = 1; k <= steps; k++) begin
                if (k * eff < lim) begin
                    exp_idx = d ? (exp_idx + 3) % 4 : (exp_idx + 1) % 4;
                    exp_pos = d ? exp_pos - 16'd1 : exp_pos + 16'd1;
                    ev.t = a + k * eff;
                    ev.ab = seq[exp_idx];
                    ev.pos = exp_pos;
                    ev.dn = (k == steps);
                    sb.push_back(ev);
                end
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'(steps != 0));
    endtask

    task automatic wait_done(int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL run_timeout: got %0d pending events expected 0",
                     sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    localparam int BIG = 1 << 30;

    initial begin
        int a;
        seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
        n_chk = 0; n_fail = 0; mon_en = 1'b0; prev_ab = 2'b00;
        exp_idx = 0; exp_pos = 16'h0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0;
        cmd_steps = 16'h0; cmd_period = 16'h0; abort = 1'b0;

        vec[0] = '{1'b1, 1'b0, 4, 3, 2'b00, 16'h0004};
        vec[1] = '{1'b1, 1'b1, 2, 5, 2'b11, 16'hFFFE};
        vec[2] = '{1'b0, 1'b0, 0, 7, 2'b11, 16'hFFFE};
        vec[3] = '{1'b0, 1'b0, 2, 0, 2'b00, 16'h0000};
        vec[4] = '{1'b0, 1'b1, 3, 2, 2'b10, 16'hFFFD};
        vec[5] = '{1'b0, 1'b0, 1, 1, 2'b11, 16'hFFFE};

        repeat (2) @(negedge clk);
        do_reset();

        foreach (vec[i]) begin
            if (vec[i].rst) do_reset();
            send(vec[i].dir, vec[i].steps, vec[i].per, BIG, a);
            wait_done(vec[i].steps * (vec[i].per == 0 ? 1 : vec[i].per) + 10);
            chk($sformatf("v%0d_ab", i), 32'({enc_a, enc_b}), 32'(vec[i].fab));
            chk($sformatf("v%0d_pos", i), 32'(position), 32'(vec[i].fpos));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'h0);
            chk($sformatf("v%0d_ready", i), 32'(cmd_ready), 32'h1);
        end

        // Abort: steps 10, period 3, abort sampled at accept+7.
        do_reset();
        send(1'b0, 10, 3, 7, a);
        repeat (6) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'h1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy_after", 32'(busy), 32'h0);
        chk("abort_ready_after", 32'(cmd_ready), 32'h1);
        chk("abort_done", 32'(done), 32'h0);
        repeat (6) @(negedge clk);
        chk("abort_ab", 32'({enc_a, enc_b}), 32'(2'b11));
        chk("abort_pos", 32'(position), 32'h2);
        chk("abort_pending", 32'(sb.size()), 32'h0);
        abort = 1'b1;
        send(1'b0, 1, 1, BIG, a);
        abort = 1'b0;
        wait_done(10);
        chk("post_abort_ab", 32'({enc_a, enc_b}), 32'(2'b01));
        chk("post_abort_pos", 32'(position), 32'h3);

        // Position wrap 0x7FFF -> 0x8000, with cmd_valid held during RUN.
        do_reset();
        send(1'b0, 32767, 1, BIG, a);
        wait_done(32767 + 10);
        chk("wrap_pre_pos", 32'(position), 32'h7FFF);
        chk("wrap_pre_ab", 32'({enc_a, enc_b}), 32'(2'b01));
        send(1'b0, 3, 4, BIG, a);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = 1'b1;
        cmd_steps = 16'd5; cmd_period = 16'd1;
        repeat (3) begin
            @(negedge clk);
            chk("midrun_ready", 32'(cmd_ready), 32'h0);
            chk("midrun_busy", 32'(busy), 32'h1);
        end
        cmd_valid = 1'b0;
        wait_done(20);
        chk("wrap_pos", 32'(position), 32'h8002);
        chk("wrap_ab", 32'({enc_a, enc_b}), 32'(2'b11));

        // Reset mid-run, between clock edges.
        send(1'b0, 5, 3, 4, a);
        repeat (4) @(negedge clk);
        chk("rr_pre_pos", 32'(position), 32'h8003);
        mon_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rr_ab", 32'({enc_a, enc_b}), 32'(2'b00));
        chk("rr_pos", 32'(position), 32'h0);
        chk("rr_busy", 32'(busy), 32'h0);
        chk("rr_done", 32'(done), 32'h0);
        chk("rr_ready", 32'(cmd_ready), 32'h1);
        repeat (3) begin
            @(negedge clk);
            chk("rr_hold_done", 32'(done), 32'h0);
        end
        reset = 1'b0;
        sb.delete();
        exp_idx = 0; exp_pos = 16'h0; prev_ab = 2'b00; mon_en = 1'b1;
        @(negedge clk);
        chk("rr_release_done", 32'(done), 32'h0);
        send(1'b0, 1, 2, BIG, a);
        wait_done(10);
        chk("rr_after_ab", 32'({enc_a, enc_b}), 32'(2'b10));
        chk("rr_after_pos", 32'(position), 32'h1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
